// File: rtl/lfsr_checker.sv
// PRBS sink: self-synchronises a local LFSR to the received serial stream, declares lock,
// then free-runs and counts bit errors in a saturating counter.
module lfsr_checker #(
  parameter int WIDTH      = 5,
  parameter int LOCK_COUNT = 8,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] taps,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_TOP = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [MISS_W-1:0]  MISS_TOP  = MISS_W'(LOSS_COUNT - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pred;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pred    = ^(taps & hist_q);
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (clear) begin
      state_d = HUNT;
      hist_d  = '0;
      fill_d  = '0;
      match_d = '0;
      miss_d  = '0;
      cnt_d   = '0;
    end else if (valid) begin
      case (state_q)
        HUNT: begin
          // Always load the received bit so the register re-aligns to the stream.
          hist_d = {hist_q[WIDTH-2:0], in_bit};
          if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
          end else if (in_bit == pred) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q == MATCH_TOP) begin
              state_d = LOCK;
              miss_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCK: begin
          // Free-run on the prediction so a line error cannot corrupt later predictions.
          hist_d = {hist_q[WIDTH-2:0], pred};
          if (in_bit != pred) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (miss_q == MISS_TOP) begin
              state_d = HUNT;
              fill_d  = '0;
              match_d = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign locked    = (state_q == LOCK);
  assign err       = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a reference PRBS generator drives two checkers (16-bit and 4-bit
// error counters); a per-cycle scoreboard plus scenario-specific inline checks.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        in_bit = 1'b0;
  logic [4:0]  taps = 5'b10100;
  logic        locked, err;
  logic [15:0] err_count;
  logic        locked_s, err_s;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in_bit(in_bit), .taps(taps),
    .locked(locked), .err(err), .err_count(err_count)
  );

  lfsr_checker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid), .in_bit(in_bit), .taps(taps),
    .locked(locked_s), .err(err_s), .err_count(cnt_s)
  );

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  logic [4:0] gen = 5'b00001;
  bit m_lock, m_err;
  int m_clean, m_miss, m_cnt, m_cnt4;

  function automatic logic gen_next();
    logic nb;
    nb  = ^(taps & gen);
    gen = {gen[3:0], nb};
    return nb;
  endfunction

  function automatic void model_reset();
    m_lock = 0; m_err = 0; m_clean = 0; m_miss = 0; m_cnt = 0; m_cnt4 = 0;
  endfunction

  // Scenario-level model: with a correctly aligned checker every flipped bit is a mismatch.
  task automatic drive_bit(input logic v, input logic flip, input logic clr);
    logic b;
    exp_t e;
    @(negedge clk);
    if (v) b = gen_next() ^ flip;
    else   b = logic'($urandom_range(0, 1));
    valid = v; in_bit = b; clear = clr;
    if (clr) begin
      model_reset();
    end else if (v) begin
      if (!m_lock) begin
        m_err = 0;
        if (flip) m_clean = 0;
        else m_clean++;
        if (m_clean == 13) begin m_lock = 1; m_miss = 0; end
      end else if (flip) begin
        m_err = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
        m_miss++;
        if (m_miss == 3) begin m_lock = 0; m_clean = 0; m_miss = 0; end
      end else begin
        m_err = 0; m_miss = 0;
      end
    end else begin
      m_err = 0;
    end
    e.locked = m_lock; e.err = m_err; e.cnt = 16'(m_cnt); e.cnt4 = 4'(m_cnt4);
    sb_q.push_back(e);
    @(posedge clk); #2;
    valid = 1'b0; clear = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      txn++;
      checks++;
      $display("txn %0d valid=%b bit=%b clear=%b locked=%b err=%b cnt=%0d cnt4=%0d",
               txn, valid, in_bit, clear, locked, err, err_count, cnt_s);
      if (locked !== mon_e.locked || err !== mon_e.err || err_count !== mon_e.cnt ||
          locked_s !== mon_e.locked || err_s !== mon_e.err || cnt_s !== mon_e.cnt4) begin
        errors++;
        $display("FAIL scoreboard txn %0d: got locked=%b/%b err=%b/%b cnt=%0d/%0d, expected locked=%b err=%b cnt=%0d/%0d",
                 txn, locked, locked_s, err, err_s, err_count, cnt_s,
                 mon_e.locked, mon_e.err, mon_e.cnt, mon_e.cnt4);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    gen = 5'b00001;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_initial: got locked=%b err=%b cnt=%0d, expected 0 0 0", locked, err, err_count);
    end
    do_reset();
    for (int i = 1; i <= 13; i++) drive_bit(1'b1, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || err_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_precondition: got err=%b cnt=%0d, expected 1 1", err, err_count);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || locked_s !== 1'b0 || cnt_s !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got locked=%b err=%b cnt=%0d cnt4=%0d, expected 0 0 0 0",
               locked, err, err_count, cnt_s);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      drive_bit(1'b1, 1'b0, 1'b0);
      if (i == 12 || i == 13) begin
        checks++;
        if (locked !== (i == 13)) begin
          errors++;
          $display("FAIL clean_lock_bit%0d: got locked=%b, expected %b", i, locked, (i == 13));
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL clean_200: got locked=%b cnt=%0d, expected 1 0", locked, err_count);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    for (int i = 1; i <= 79; i++) begin
      drive_bit(1'b1, (i == 60), 1'b0);
      if (i == 60 || i == 61) begin
        checks++;
        if (err !== (i == 60) || err_count !== 16'd1 || locked !== 1'b1) begin
          errors++;
          $display("FAIL single_err_bit%0d: got err=%b cnt=%0d locked=%b, expected %b 1 1",
                   i, err, err_count, locked, (i == 60));
        end
      end
    end
  endtask

  task automatic test_loss_relock();
    for (int i = 80; i <= 150; i++) begin
      drive_bit(1'b1, (i >= 80 && i <= 82), 1'b0);
      if (i == 82) begin
        checks++;
        if (locked !== 1'b0 || err_count !== 16'd4) begin
          errors++;
          $display("FAIL loss_bit82: got locked=%b cnt=%0d, expected 0 4", locked, err_count);
        end
      end
      if (i == 94 || i == 95) begin
        checks++;
        if (locked !== (i == 95)) begin
          errors++;
          $display("FAIL relock_bit%0d: got locked=%b, expected %b", i, locked, (i == 95));
        end
      end
    end
    checks++;
    if (err_count !== 16'd4 || locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_count: got cnt=%0d locked=%b, expected 4 1", err_count, locked);
    end
  endtask

  task automatic test_valid_gaps();
    int n = 0;
    do_reset();
    for (int c = 0; n < 40; c++) begin
      if (c % 2 == 0) begin
        n++;
        drive_bit(1'b1, (n == 20), 1'b0);
        if (n == 12 || n == 13) begin
          checks++;
          if (locked !== (n == 13)) begin
            errors++;
            $display("FAIL gaps_lock_n%0d: got locked=%b, expected %b", n, locked, (n == 13));
          end
        end
      end else begin
        drive_bit(1'b0, 1'b0, 1'b0);
        if (n == 20) begin
          checks++;
          if (err !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL gaps_idle_after_err: got err=%b cnt=%0d locked=%b, expected 0 1 1",
                     err, err_count, locked);
          end
        end
      end
    end
  endtask

  task automatic test_clear_saturate();
    drive_bit(1'b1, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || cnt_s !== 4'd0) begin
      errors++;
      $display("FAIL clear: got locked=%b cnt=%0d cnt4=%0d, expected 0 0 0", locked, err_count, cnt_s);
    end
    for (int i = 1; i <= 13; i++) begin
      drive_bit(1'b1, 1'b0, 1'b0);
      if (i == 12 || i == 13) begin
        checks++;
        if (locked !== (i == 13)) begin
          errors++;
          $display("FAIL clear_relock_bit%0d: got locked=%b, expected %b", i, locked, (i == 13));
        end
      end
    end
    for (int k = 0; k < 20; k++) begin
      drive_bit(1'b1, 1'b1, 1'b0);
      repeat (4) drive_bit(1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (err_count !== 16'd20 || cnt_s !== 4'd15 || locked_s !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d cnt4=%0d locked4=%b, expected 20 15 1",
               err_count, cnt_s, locked_s);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_relock();
    test_valid_gaps();
    test_clear_saturate();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
